rr_mux8_arbiter: RTL and testbench
==================================

Name: rr_mux8_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8:1 data multiplexer between N requesters.
- Each requester sends packets of DW-bit beats over valid/ready with a last flag.
- The block grants one requester at a time and drives the mux select.
- The grant is held for the whole packet; the selected beat is forwarded through a registered output stage to a single downstream consumer.

Parameters:
N, 8, number of requesters (mux inputs); power of two, 2..8
DW, 8, data width per beat
SW, 3, select width, equal to log2(N)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  N  per-requester beat valid
in_data  input  N*DW  per-requester beat data; requester i occupies bits [i*DW +: DW]
in_last  input  N  per-requester last-beat-of-packet flag
in_ready  output  N  per-requester ready; at most one bit high at any time
out_valid  output  1  registered output beat valid
out_data  output  DW  registered output beat data
out_last  output  1  registered last flag
out_sel  output  SW  index of the requester that sourced the current output beat
out_ready  input  1  downstream ready

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately):
  - state=IDLE, ptr=0, gnt=0
  - out_valid=0, out_data=0, out_last=0, out_sel=0, in_ready=0
- Release of rst_n is sampled at the next clk edge.
- FSM states: IDLE, LOCKED.
- IDLE:
  - in_ready all 0.
  - If any in_valid is set, gnt is loaded with the first index i scanning ptr, ptr+1, ... mod N with in_valid[i]=1, and state goes to LOCKED on the next edge.
  - If no in_valid is set, the FSM stays in IDLE.
- LOCKED:
  - in_ready[gnt] = (!out_valid || out_ready); all other in_ready bits are 0.
  - Beat transfer when in_valid[gnt] && in_ready[gnt]: out_data<=in_data[gnt], out_last<=in_last[gnt], out_sel<=gnt, out_valid<=1.
  - If the transferred beat has in_last[gnt]=1: state<=IDLE and ptr<=(gnt+1) mod N. N is a power of two, so wrap N-1 -> 0 is natural truncation.
- Output stage:
  - If out_valid && out_ready and no new beat is loaded, out_valid<=0.
  - While out_valid && !out_ready, out_data, out_last and out_sel hold stable.
- Latency:
  - Request at cycle 0 in IDLE -> LOCKED and in_ready at cycle 1 -> out_valid at cycle 2.
  - Within a packet, throughput is 1 beat/cycle when out_ready=1.
  - There is exactly one bubble cycle (IDLE) between packets.
- Boundary conditions:
  - Simultaneous requests: round-robin from ptr; no requester waits more than N-1 packets.
  - Single active requester: re-granted after the one-cycle IDLE bubble.
  - Granted requester deasserts in_valid mid-packet: the block stays LOCKED indefinitely with no timeout; other requesters are ignored.
  - in_valid on a non-granted requester: ignored; its in_ready stays 0.
  - Single-beat packet (last on first beat): LOCKED lasts one transfer cycle only.
  - out_ready low during the last beat: the FSM has already returned to IDLE, and the next grant may occur. New data loads only after the held beat drains.
  - rst_n asserted mid-packet: packet is dropped and out_valid falls asynchronously; arbitration restarts from ptr=0.
- Ordering: out_sel is always equal to the gnt that sourced the registered beat.

Test Plan:
- Reset then in_valid=8'b0000_0100, 3-beat packet data 0x11,0x22,0x33 with last on 0x33, out_ready=1 -> in_ready=8'b0000_0100 from cycle 1; out_data 0x11,0x22,0x33 on cycles 2-4 with out_sel=2 and out_last only with 0x33; ptr=3 afterwards.
- All 8 in_valid held, 1-beat packets, out_ready=1 -> grant order 0,1,2,...,7,0 with one IDLE cycle between grants; out_sel follows the same sequence.
- ptr=7, requests on 7 and 0 -> 7 granted first, then 0 (wrap); ptr returns to 1.
- Requester 1 granted with 4-beat packet, out_ready toggling 1,0,0,1,... -> in_ready[1] low whenever out_valid && !out_ready; out_data holds during stalls; no beat lost or duplicated.
- Requester 5 granted, drops in_valid after beat 2 while requester 3 requests -> stays LOCKED on 5 and in_ready[3]=0 until 5 resumes and sends last.
- rst_n pulsed low mid-packet with out_valid=1 -> out_valid/out_data/in_ready drop to 0 without a clock edge; after release, requests on 4 and 6 -> 4 granted (ptr=0).

Source files
------------

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter sharing one N:1 data mux; grant is held for a whole packet.
// Latency: request seen in IDLE -> in_ready next cycle -> registered out_valid the cycle after.
// Backpressure: in_ready[gnt] only while the output register is empty or draining (out_ready).
module rr_mux8_arbiter #(
    parameter int N  = 8,
    parameter int DW = 8,
    parameter int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_valid,
    input  logic [N*DW-1:0] in_data,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    output logic [SW-1:0]   out_sel,
    input  logic            out_ready
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state;
    logic [SW-1:0] ptr;
    logic [SW-1:0] gnt;
    logic [SW-1:0] pick;
    logic [SW-1:0] idx;
    logic          found;
    logic          xfer;

    // Scan requesters starting at ptr; the first valid one in wrap order wins.
    // SW-bit addition wraps N-1 -> 0 for free because N is a power of two.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = ptr + SW'(i);
            if (!found && in_valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Only the locked requester may see ready, and only when the output slot can take a beat.
    always_comb begin
        in_ready = '0;
        if (state == LOCKED) begin
            in_ready[gnt] = !out_valid || out_ready;
        end
    end

    assign xfer = (state == LOCKED) && in_valid[gnt] && in_ready[gnt];

    // Arbitration FSM plus the registered output stage; a last beat frees the mux immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else begin
            if (state == IDLE) begin
                if (found) begin
                    gnt   <= pick;
                    state <= LOCKED;
                end
            end else begin
                if (xfer && in_last[gnt]) begin
                    state <= IDLE;
                    ptr   <= gnt + SW'(1);
                end
            end

            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[gnt*DW +: DW];
                out_last  <= in_last[gnt];
                out_sel   <= gnt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Bench for rr_mux8_arbiter: directed cycle checks plus randomized packets vs a packet-level model.
// Latency: checks sample at the falling edge, after each rising-edge update.
// Backpressure: out_ready is driven constant, patterned or random per scenario.
module tb_rr_mux8_arbiter;

    localparam int N  = 8;
    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    in_valid = '0;
    logic [N*DW-1:0] in_data = '0;
    logic [N-1:0]    in_last = '0;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [2:0]      out_sel;
    logic            out_ready = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    // per-requester pending beats, captured output stream, expected stream
    beat_t q[N][$];
    int    plen[N][$];
    bit    mid[N];
    beat_t got_b[$];
    int    got_s[$];
    int    got_c[$];
    beat_t exp_b[$];
    int    exp_s[$];

    rr_mux8_arbiter #(.N(N), .DW(DW), .SW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = '0;
        in_last  = '0;
        in_data  = '0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            plen[i].delete();
            mid[i] = 1'b0;
        end
    endtask

    task automatic add_packet(input int r, input int len, input logic [DW-1:0] base, input bit rnd);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d = rnd ? DW'($urandom) : base + DW'(k);
            b.l = (k == len - 1);
            q[r].push_back(b);
        end
        plen[r].push_back(len);
    endtask

    // Packet-level reference: at each arbitration pick the first requester with pending
    // packets scanning from ptr, emit that whole packet, then move ptr just past it.
    task automatic build_expected(input int start_ptr);
        int pos[N];
        int ptr;
        int len;
        bit any;
        exp_b.delete();
        exp_s.delete();
        ptr = start_ptr;
        for (int i = 0; i < N; i++) pos[i] = 0;
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int k = 0; k < N; k++) begin
                int r;
                r = (ptr + k) % N;
                if (!any && plen[r].size() > 0) begin
                    len = plen[r].pop_front();
                    for (int b = 0; b < len; b++) begin
                        exp_b.push_back(q[r][pos[r] + b]);
                        exp_s.push_back(r);
                    end
                    pos[r] += len;
                    ptr = (r + 1) % N;
                    any = 1'b1;
                end
            end
        end
    endtask

    // Drives queued beats, consumes output; mode 0: ready=1, 1: random, 2: pattern 1,0,0,1.
    // gaps lets the granted requester drop valid mid-packet at random.
    task automatic run_engine(input int mode, input bit gaps, input int budget);
        bit prev_stall;
        bit finished;
        bit empty;
        logic [DW-1:0] pd;
        logic pl;
        logic [2:0] ps;
        int cyc;
        got_b.delete();
        got_s.delete();
        got_c.delete();
        prev_stall = 1'b0;
        finished = 1'b0;
        pd = '0;
        pl = 1'b0;
        ps = '0;
        for (cyc = 0; cyc < budget && !finished; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                total_cnt++;
                if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl || out_sel !== ps)
                    $display("FAIL stall_hold: got v%b d%h l%b s%0d expected v1 d%h l%b s%0d",
                             out_valid, out_data, out_last, out_sel, pd, pl, ps);
                else
                    pass_cnt++;
            end
            empty = 1'b1;
            for (int i = 0; i < N; i++) if (q[i].size() > 0) empty = 1'b0;
            if (empty && !out_valid) begin
                finished = 1'b1;
            end else begin
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = ($urandom_range(0, 3) != 0);
                    default: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                endcase
                for (int i = 0; i < N; i++) begin
                    if (q[i].size() > 0) begin
                        in_valid[i] = !(gaps && mid[i] && $urandom_range(0, 2) == 0);
                        in_data[i*DW +: DW] = q[i][0].d;
                        in_last[i] = q[i][0].l;
                    end else begin
                        in_valid[i] = 1'b0;
                        in_data[i*DW +: DW] = '0;
                        in_last[i] = 1'b0;
                    end
                end
                #1;
                total_cnt++;
                if ($countones(in_ready) > 1)
                    $display("FAIL ready_onehot: got %b expected at most one bit", in_ready);
                else
                    pass_cnt++;
                if (out_valid && !out_ready) begin
                    total_cnt++;
                    if (in_ready !== '0)
                        $display("FAIL ready_in_stall: got %b expected 00000000", in_ready);
                    else
                        pass_cnt++;
                end
                if (out_valid && out_ready) begin
                    got_b.push_back('{d: out_data, l: out_last});
                    got_s.push_back(int'(out_sel));
                    got_c.push_back(cyc);
                end
                prev_stall = out_valid && !out_ready;
                pd = out_data;
                pl = out_last;
                ps = out_sel;
                for (int i = 0; i < N; i++) begin
                    if (in_valid[i] && in_ready[i]) begin
                        mid[i] = !q[i][0].l;
                        void'(q[i].pop_front());
                    end
                end
            end
        end
        in_valid = '0;
        in_last  = '0;
        total_cnt++;
        if (!finished)
            $display("FAIL engine_timeout: got %0d cycles expected completion", budget);
        else
            pass_cnt++;
    endtask

    task automatic compare_stream(input string name);
        int n;
        total_cnt++;
        if (got_b.size() != exp_b.size())
            $display("FAIL %s_count: got %0d beats expected %0d", name, got_b.size(), exp_b.size());
        else
            pass_cnt++;
        n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
        for (int j = 0; j < n; j++) begin
            total_cnt++;
            if (got_b[j] !== exp_b[j] || got_s[j] != exp_s[j])
                $display("FAIL %s_beat%0d: got d%h l%b s%0d expected d%h l%b s%0d", name, j,
                         got_b[j].d, got_b[j].l, got_s[j], exp_b[j].d, exp_b[j].l, exp_s[j]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 ||
            out_sel !== 3'd0 || in_ready !== 8'h00)
            $display("FAIL reset_state: got v%b d%h l%b s%0d r%b expected all zero",
                     out_valid, out_data, out_last, out_sel, in_ready);
        else
            pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_packet();
        logic [DW-1:0] dat[3];
        dat[0] = 8'h11;
        dat[1] = 8'h22;
        dat[2] = 8'h33;
        apply_reset();
        in_valid = 8'b0000_0100;
        in_data[2*DW +: DW] = dat[0];
        in_last = '0;
        out_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 8'b0000_0100 || out_valid !== 1'b0)
            $display("FAIL sp_cycle1: got r%b v%b expected r00000100 v0", in_ready, out_valid);
        else
            pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b1 || out_data !== dat[k] || out_sel !== 3'd2 || out_last !== (k == 2))
                $display("FAIL sp_beat%0d: got v%b d%h s%0d l%b expected v1 d%h s2 l%b",
                         k, out_valid, out_data, out_sel, out_last, dat[k], (k == 2));
            else
                pass_cnt++;
            if (k < 2) begin
                in_data[2*DW +: DW] = dat[k + 1];
                in_last[2] = (k == 1);
            end else begin
                in_valid = '0;
                in_last = '0;
                #1;
                total_cnt++;
                if (in_ready !== 8'h00)
                    $display("FAIL sp_idle_after_last: got %b expected 00000000", in_ready);
                else
                    pass_cnt++;
            end
        end
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL sp_drain: got %b expected 0", out_valid);
        else
            pass_cnt++;
        // ptr should now be 3: simultaneous requests on 2 and 3 grant 3 first
        clear_queues();
        add_packet(2, 1, 8'hA2, 1'b0);
        add_packet(3, 1, 8'hA3, 1'b0);
        build_expected(3);
        run_engine(0, 1'b0, 50);
        compare_stream("sp_ptr3");
    endtask

    task automatic test_round_robin();
        apply_reset();
        clear_queues();
        for (int i = 0; i < N; i++) add_packet(i, 1, DW'(i), 1'b0);
        add_packet(0, 1, 8'h80, 1'b0);
        build_expected(0);
        run_engine(0, 1'b0, 100);
        compare_stream("rr");
        for (int j = 1; j < got_c.size(); j++) begin
            total_cnt++;
            if (got_c[j] - got_c[j - 1] != 2)
                $display("FAIL rr_bubble%0d: got spacing %0d expected 2", j, got_c[j] - got_c[j - 1]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        // ptr is 1 after the round-robin run; one packet on 6 moves it to 7
        clear_queues();
        add_packet(6, 1, 8'h66, 1'b0);
        run_engine(0, 1'b0, 50);
        clear_queues();
        add_packet(7, 2, 8'h70, 1'b0);
        add_packet(0, 1, 8'h00, 1'b0);
        build_expected(7);
        run_engine(0, 1'b0, 50);
        compare_stream("wrap_7_0");
        clear_queues();
        add_packet(0, 1, 8'h0A, 1'b0);
        add_packet(1, 1, 8'h1A, 1'b0);
        build_expected(1);
        run_engine(0, 1'b0, 50);
        compare_stream("wrap_ptr1");
    endtask

    task automatic test_stall();
        clear_queues();
        add_packet(1, 4, 8'hA1, 1'b0);
        build_expected(0);
        run_engine(2, 1'b0, 100);
        compare_stream("stall");
    endtask

    task automatic test_mid_drop();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 8'h20;
        in_data[5*DW +: DW] = 8'h51;
        in_last = '0;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 8'h20)
            $display("FAIL md_grant5: got %b expected 00100000", in_ready);
        else
            pass_cnt++;
        @(negedge clk);
        in_data[5*DW +: DW] = 8'h52;
        @(negedge clk);
        in_valid = 8'h08;
        in_data[3*DW +: DW] = 8'h31;
        in_last[3] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            total_cnt++;
            if (in_ready !== 8'h20 || (k > 0 && out_valid !== 1'b0))
                $display("FAIL md_locked%0d: got r%b v%b expected r00100000 v%b",
                         k, in_ready, out_valid, (k == 0));
            else
                pass_cnt++;
            @(negedge clk);
        end
        in_valid = 8'h28;
        in_data[5*DW +: DW] = 8'h53;
        in_last[5] = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'h53 || out_sel !== 3'd5 || out_last !== 1'b1)
            $display("FAIL md_last5: got v%b d%h s%0d l%b expected v1 d53 s5 l1",
                     out_valid, out_data, out_sel, out_last);
        else
            pass_cnt++;
        in_valid = 8'h08;
        #1;
        total_cnt++;
        if (in_ready !== 8'h00)
            $display("FAIL md_bubble: got %b expected 00000000", in_ready);
        else
            pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 8'h08)
            $display("FAIL md_grant3: got %b expected 00001000", in_ready);
        else
            pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'h31 || out_sel !== 3'd3)
            $display("FAIL md_beat3: got v%b d%h s%0d expected v1 d31 s3", out_valid, out_data, out_sel);
        else
            pass_cnt++;
        in_valid = '0;
        in_last = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_packet();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 8'h02;
        in_data[1*DW +: DW] = 8'h77;
        in_last = '0;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'h77 || in_ready !== 8'h02)
            $display("FAIL rm_before: got v%b d%h r%b expected v1 d77 r00000010",
                     out_valid, out_data, in_ready);
        else
            pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 8'h00 || out_sel !== 3'd0)
            $display("FAIL rm_async: got v%b d%h r%b s%0d expected all zero",
                     out_valid, out_data, in_ready, out_sel);
        else
            pass_cnt++;
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_queues();
        add_packet(4, 1, 8'h44, 1'b0);
        add_packet(6, 1, 8'h66, 1'b0);
        build_expected(0);
        run_engine(0, 1'b0, 50);
        compare_stream("rm_restart");
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            apply_reset();
            clear_queues();
            for (int r = 0; r < N; r++) begin
                int np;
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) add_packet(r, $urandom_range(1, 4), 8'h00, 1'b1);
            end
            build_expected(0);
            run_engine(1, 1'b1, 3000);
            compare_stream("rand");
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_wrap();
        test_stall();
        test_mid_drop();
        test_reset_mid_packet();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
